// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the
// sequential BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_ADJ    = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd8;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble nibble correction:
// subtract 3 from a BCD nibble that is >= 8.
module bcd_nibble_adj
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // correct a nibble that borrowed a half-ten on the shift
  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) dout = din - BCD_ADJ;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using
// reverse double-dabble, start/busy/done handshake.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCD_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [BIN_W-1:0]      BIN_OUT,
  output logic                  ERR
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BIN_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shift;
  logic [SR_W-1:0]   sr_adj;
  logic [CNT_W-1:0]  cnt;
  logic              in_err;
  logic              last;

  assign sr_shift = sr >> 1;
  assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];
  assign last = (cnt == CNT_LAST);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din  (sr_shift[BIN_W+4*g +: 4]),
      .dout (sr_adj[BIN_W+4*g +: 4])
    );
  end

  // flag any input digit outside 0..9
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD_IN[4*i +: 4] > BCD_MAX) in_err = 1'b1;
    end
  end

  // state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (START) state_nxt = in_err ? ST_FIN : ST_CONV;
      end
      ST_CONV: begin
        if (last) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // load, iterate and capture the result
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sr      <= '0;
      cnt     <= '0;
      BIN_OUT <= '0;
      ERR     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            sr  <= {BCD_IN, {BIN_W{1'b0}}};
            cnt <= '0;
            ERR <= in_err;
            if (in_err) BIN_OUT <= '0;
          end
        end
        ST_CONV: begin
          sr <= sr_adj;
          if (last) BIN_OUT <= sr_adj[BIN_W-1:0];
          else      cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == ST_CONV);
  assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq with a
// result scoreboard; 2-digit and 3-digit DUTs.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bcd;
  logic        busy, done, err;
  logic [6:0]  bin;
  logic        start3;
  logic [11:0] bcd3;
  logic        busy3, done3, err3;
  logic [9:0]  bin3;

  int total = 0;
  int bad   = 0;
  logic [10:0] sb[$];

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .START    (start),
    .BCD_IN   (bcd),
    .BUSY     (busy),
    .DONE     (done),
    .BIN_OUT  (bin),
    .ERR      (err)
  );

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .START    (start3),
    .BCD_IN   (bcd3),
    .BUSY     (busy3),
    .DONE     (done3),
    .BIN_OUT  (bin3),
    .ERR      (err3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // decimal reference: {err, value}
  function automatic logic [10:0] model(
    input logic [15:0] b, input int n);
    int v = 0;
    int m = 1;
    logic e = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (b[4*i +: 4] > 4'd9) e = 1'b1;
      v += int'(b[4*i +: 4]) * m;
      m *= 10;
    end
    return e ? {1'b1, 10'd0} : {1'b0, 10'(v)};
  endfunction

  task automatic run2(input string tag,
                      input logic [7:0] b,
                      input int glitch_at,
                      input logic [7:0] gb);
    logic [10:0] e;
    int edges;
    int busy_n;
    @(negedge clk);
    bcd = b;
    start = 1'b1;
    e = model({8'h00, b}, 2);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    busy_n = 0;
    while (!done && edges < 40) begin
      if (busy) busy_n++;
      if (glitch_at > 0 && busy &&
          busy_n == glitch_at) begin
        start = 1'b1;
        bcd = gb;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({tag, "_lat"}, edges, e[10] ? 1 : 8);
    check({tag, "_busy"}, busy_n, e[10] ? 0 : 7);
    e = sb.pop_front();
    check({tag, "_bin"}, {25'd0, bin}, {25'd0, e[6:0]});
    check({tag, "_err"}, {31'd0, err}, {31'd0, e[10]});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run3(input string tag,
                      input logic [11:0] b);
    logic [10:0] e;
    int edges;
    @(negedge clk);
    bcd3 = b;
    start3 = 1'b1;
    e = model({4'h0, b}, 3);
    sb.push_back(e);
    @(negedge clk);
    start3 = 1'b0;
    edges = 1;
    while (!done3 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_lat"}, edges, e[10] ? 1 : 11);
    e = sb.pop_front();
    check({tag, "_bin"}, {22'd0, bin3}, {22'd0, e[9:0]});
    check({tag, "_err"}, {31'd0, err3}, {31'd0, e[10]});
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd    = 8'h00;
    start3 = 1'b0;
    bcd3   = 12'h000;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bin",  {25'd0, bin},  32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run2("c99", 8'h99, 0, 8'h00);
    run2("c47", 8'h47, 0, 8'h00);
    run2("c00", 8'h00, 0, 8'h00);
    run2("cA5", 8'hA5, 0, 8'h00);
    run2("c63", 8'h63, 3, 8'h12);
    run2("c12", 8'h12, 0, 8'h00);

    @(negedge clk);
    bcd = 8'h58;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_done", {31'd0, done}, 32'd0);
    check("ar_bin",  {25'd0, bin},  32'd0);
    check("ar_err",  {31'd0, err},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run2("c25", 8'h25, 0, 8'h00);

    run3("t999", 12'h999);
    run3("t100", 12'h100);
    run3("t9A0", 12'h9A0);
    run3("t507", 12'h507);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
